rcvr: RTL and testbench

//  UART receive half of the s4x7 diag/debug serial port, the counterpart of the

---
 rtl/rcvr.sv | 190 +++++++++++++++++++
 tb/tb_rcvr.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rcvr.sv
// rcvr: 8N1 UART receiver for the s4x7 diag/debug serial port.
// rxd is synchronised by two flops, the start edge is found on the synchronised line, and each
// bit is sampled in the middle of its period using a 13-bit down-counter.
// Optional feature: define RCVR_MAJORITY_VOTE_EN to take each sample as a 2-of-3 vote around
// the sample point. Decisions then land one clock later.
module rcvr #(
    parameter int unsigned BAUD_DIV = 867
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rd_stb,
    output logic [7:0] dout,
    output logic       rx_stb,
    output logic       rda,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [12:0] DIV_LOAD  = 13'(BAUD_DIV);
    localparam logic [12:0] HALF_LOAD = 13'(BAUD_DIV >> 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBrk} state_e;

    state_e      state_q, state_d;
    logic        rxd_meta_q, rxd_s_q, rxd_prev_q;
    logic [12:0] clk_div_q, clk_div_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  dout_q, dout_d;
    logic        rx_stb_q, rx_stb_d;
    logic        rda_q, rda_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;

    logic active, div_zero, sample_now, sample_bit, stop_good, stop_bad;

    assign active   = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
    assign div_zero = (clk_div_q == 13'd0);

    // Two-flop synchroniser plus a delayed copy for start-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
            rxd_prev_q <= rxd_s_q;
        end
    end

`ifdef RCVR_MAJORITY_VOTE_EN
    logic vote_pend_q, vote_a_q, vote_b_q;

    // Hold the clk_div==1 and clk_div==0 samples; the vote completes with the next clock's value.
    always_ff @(posedge clk) begin
        if (rst) begin
            vote_pend_q <= 1'b0;
            vote_a_q    <= 1'b1;
            vote_b_q    <= 1'b1;
        end else begin
            vote_pend_q <= active && div_zero;
            vote_a_q    <= rxd_prev_q;
            vote_b_q    <= rxd_s_q;
        end
    end

    assign sample_now = vote_pend_q;
    assign sample_bit = (vote_a_q & vote_b_q) | (vote_a_q & rxd_s_q) | (vote_b_q & rxd_s_q);
`else
    assign sample_now = active && div_zero;
    assign sample_bit = rxd_s_q;
`endif

    // Receive FSM next state; the bit counter free-runs at the bit period while a frame is open.
    always_comb begin
        state_d   = state_q;
        clk_div_d = clk_div_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        if (active) begin
            clk_div_d = div_zero ? DIV_LOAD : clk_div_q - 13'd1;
        end
        unique case (state_q)
            StIdle: begin
                if (!rxd_s_q && rxd_prev_q) begin
                    clk_div_d = HALF_LOAD;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (sample_now) begin
                    if (!sample_bit) begin
                        bit_idx_d = 3'd0;
                        state_d   = StData;
                    end else begin
                        state_d = StIdle;  // glitch, not a start bit
                    end
                end
            end
            StData: begin
                if (sample_now) begin
                    shift_d   = {sample_bit, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (sample_now) begin
                    if (sample_bit) begin
                        stop_good = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = StBrk;
                    end
                end
            end
            StBrk: begin
                // A break holds the line low; wait for mark so it cannot retrigger.
                if (rxd_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output next state: byte delivery, error pulse and read handshake.
    always_comb begin
        dout_d      = dout_q;
        rx_stb_d    = 1'b0;
        frame_err_d = 1'b0;
        rda_d       = rda_q;
        overrun_d   = overrun_q;
        if (rd_stb) begin
            rda_d     = 1'b0;
            overrun_d = 1'b0;
        end
        if (stop_good) begin
            dout_d   = shift_q;
            rx_stb_d = 1'b1;
            rda_d    = 1'b1;
            if (rda_q && !rd_stb) begin
                overrun_d = 1'b1;
            end
        end
        if (stop_bad) begin
            frame_err_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            clk_div_q   <= 13'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            dout_q      <= 8'h00;
            rx_stb_q    <= 1'b0;
            rda_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_div_q   <= clk_div_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            rx_stb_q    <= rx_stb_d;
            rda_q       <= rda_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign dout      = dout_q;
    assign rx_stb    = rx_stb_q;
    assign rda       = rda_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_rcvr.sv
// tb_rcvr: the whole rxd/rst/rd_stb waveform is laid out in arrays first, a frame-level model
// predicts every output cycle from it, then the waveform is played into the DUT.
`timescale 1ns/1ps
module tb_rcvr;

    localparam int unsigned BAUD_DIV = 15;
    localparam int P    = BAUD_DIV + 1;
    localparam int HALF = BAUD_DIV / 2;
`ifdef RCVR_MAJORITY_VOTE_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam int LAT  = 155 + MAJ;  // rxd fall to visible rx_stb
    localparam int MAXC = 20000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rd_stb = 1'b0;
    logic [7:0] dout;
    logic       rx_stb, rda, frame_err, overrun;

    rcvr #(.BAUD_DIV(BAUD_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rd_stb    (rd_stb),
        .dout      (dout),
        .rx_stb    (rx_stb),
        .rda       (rda),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Index c = value driven just after clock edge c.
    bit          rxd_h[MAXC];
    bit          rst_h[MAXC];
    bit          rd_h[MAXC];
    bit          good_ev[MAXC];
    bit          bad_ev[MAXC];
    logic [7:0]  byte_ev[MAXC];
    logic [11:0] exp_o[MAXC];  // {dout, rx_stb, rda, frame_err, overrun}
    logic [11:0] act_o[MAXC];

    int n_tests = 0;
    int n_fail  = 0;
    int cur = 0;
    int nc  = 0;
    int cyc = 0;
    bit running = 1'b0;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic put(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            if (cur >= MAXC - 300) begin
                $display("FAIL stimulus: waveform exceeds %0d cycles", MAXC);
                $fatal(1);
            end
            rxd_h[cur] = v;
            cur++;
        end
    endtask

    task automatic frame(input logic [7:0] b, input int per);
        put(1'b0, per);
        for (int k = 0; k < 8; k++) put(b[k], per);
        put(1'b1, per);
    endtask

    // Synchronised line as seen by the receiver in cycle c.
    function automatic bit rs(input int c);
        if (c < 2) return 1'b1;
        if (rst_h[c-1] || rst_h[c-2]) return 1'b1;
        return rxd_h[c-2];
    endfunction

    function automatic bit rp(input int c);
        if (c < 1 || rst_h[c-1]) return 1'b1;
        return rs(c - 1);
    endfunction

    function automatic bit sv(input int t);
        bit a, b, d;
        if (MAJ == 0) return rs(t);
        a = rs(t - 1);
        b = rs(t);
        d = rs(t + 1);
        return (a & b) | (a & d) | (b & d);
    endfunction

    function automatic int first_rst(input int a, input int b);
        for (int x = a; x <= b; x++) if (rst_h[x]) return x;
        return -1;
    endfunction

    function automatic int cnt(input int a, input int b, input int pos);
        int n = 0;
        for (int x = a; x < b; x++) if (act_o[x][pos]) n++;
        return n;
    endfunction

    // Frame-level decode: start edge, mid-bit samples, stop verdict; then the read handshake.
    task automatic build_model();
        int c, ss, ts, d, r, b;
        logic [7:0] by;
        logic [7:0] dv;
        bit rv, ov, sb, fb, r_old;
        c = 0;
        while (c < nc - 200) begin
            if (rst_h[c] || rs(c) || !rp(c)) begin
                c++;
                continue;
            end
            ss = c + 1 + HALF;
            r = first_rst(c + 1, ss + MAJ);
            if (r >= 0) begin
                c = r + 1;
                continue;
            end
            if (sv(ss)) begin
                c = ss + MAJ + 1;
                continue;
            end
            for (int k = 0; k < 8; k++) by[k] = sv(ss + (k + 1) * P);
            ts = ss + 9 * P;
            d  = ts + MAJ;
            r = first_rst(c + 1, d);
            if (r >= 0) begin
                c = r + 1;
                continue;
            end
            if (sv(ts)) begin
                good_ev[d] = 1'b1;
                byte_ev[d] = by;
                c = d + 1;
            end else begin
                bad_ev[d] = 1'b1;
                b = d + 1;
                while (b < nc && !rst_h[b] && !rs(b)) b++;
                c = b + 1;
            end
        end
        dv = 8'h00; rv = 1'b0; ov = 1'b0; sb = 1'b0; fb = 1'b0;
        exp_o[0] = 12'h000;
        for (int x = 0; x < nc - 1; x++) begin
            if (rst_h[x]) begin
                dv = 8'h00; rv = 1'b0; ov = 1'b0; sb = 1'b0; fb = 1'b0;
            end else begin
                r_old = rv;
                sb = good_ev[x];
                fb = bad_ev[x];
                if (rd_h[x]) begin
                    rv = 1'b0;
                    ov = 1'b0;
                end
                if (good_ev[x]) begin
                    dv = byte_ev[x];
                    rv = 1'b1;
                    if (r_old && !rd_h[x]) ov = 1'b1;
                end
            end
            exp_o[x+1] = {dv, sb, rv, fb, ov};
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (running) begin
            act_o[cyc] = {dout, rx_stb, rda, frame_err, overrun};
            check($sformatf("cycle%0d", cyc), act_o[cyc], exp_o[cyc]);
        end
    end

    initial begin
        int f1, f2a, f2b, rd2, f3, f3b, g4, f4, f5, f5b, f6a, f6b, f7, rstart;
        for (int i = 0; i < MAXC; i++) rxd_h[i] = 1'b1;
        for (int i = 0; i < 4; i++) rst_h[i] = 1'b1;
        cur = 10;
        f1 = cur;  frame(8'hA5, P); put(1'b1, 20);
        f2a = cur; frame(8'h3C, P);
        f2b = cur; frame(8'hC3, P); put(1'b1, 20);
        rd2 = cur; rd_h[cur] = 1'b1; put(1'b1, 20);
        f3 = cur;  put(1'b0, 9 * P + 40 * P); put(1'b1, 40);
        f3b = cur; frame(8'h55, P); put(1'b1, 20);
        rd_h[cur] = 1'b1; put(1'b1, 5);
        g4 = cur;  put(1'b0, 3); put(1'b1, 30);
        f4 = cur;  frame(8'h81, P); put(1'b1, 20);
        f5 = cur;  frame(8'hFF, P); rst_h[f5 + 60] = 1'b1; put(1'b1, 20);
        f5b = cur; frame(8'h7E, P); put(1'b1, 20);
        // At period 15 the late bit-6 sample falls into bit 7; only the model judges that byte.
        f6a = cur; frame(8'h96, P - 1); put(1'b1, 20);
        f6b = cur; frame(8'h96, P + 1); put(1'b1, 20);
        f7 = cur;  frame(8'h5A, P); rd_h[f7 + LAT - 1] = 1'b1; put(1'b1, 20);
        rstart = cur;
        for (int i = 0; i < 40; i++) begin
            put(1'b1, int'($urandom_range(0, 40)));
            frame(8'($urandom_range(0, 255)), P);
        end
        for (int x = rstart; x < cur; x++) rd_h[x] = ($urandom_range(0, 149) == 0);
        put(1'b1, 250);
        nc = cur;
        build_model();

        check("model_t1", exp_o[f1 + LAT], {8'hA5, 4'b1100});
        check("model_t1_early", 12'(exp_o[f1 + LAT - 1][3]), 12'd0);
        check("model_t2", exp_o[f2b + LAT], {8'hC3, 4'b1101});

        for (int c = 0; c < nc; c++) begin
            @(posedge clk);
            #1;
            rxd    = rxd_h[c];
            rst    = rst_h[c];
            rd_stb = rd_h[c];
            cyc    = c;
            running = 1'b1;
        end
        @(negedge clk);
        #1;
        running = 1'b0;

        check("reset", act_o[2], 12'h000);
        check("t1_early", 12'(act_o[f1 + LAT - 1][3]), 12'd0);
        check("t1_byte", act_o[f1 + LAT], {8'hA5, 4'b1100});
        check("t2_count", 12'(cnt(f2a, rd2, 3)), 12'd2);
        check("t2_overrun", act_o[f2b + LAT], {8'hC3, 4'b1101});
        check("t2_read", act_o[rd2 + 1], {8'hC3, 4'b0000});
        check("t3_fe_once", 12'(cnt(f3, f3b, 1)), 12'd1);
        check("t3_hold", act_o[f3b - 1], {8'hC3, 4'b0000});
        check("t3_next", act_o[f3b + LAT], {8'h55, 4'b1100});
        check("t4_quiet", 12'(cnt(g4, f4, 3) + cnt(g4, f4, 1)), 12'd0);
        check("t4_next", act_o[f4 + LAT], {8'h81, 4'b1100});
        check("t5_reset", act_o[f5 + 62], 12'h000);
        check("t5_quiet", 12'(cnt(f5, f5b, 3)), 12'd0);
        check("t5_next", act_o[f5b + LAT], {8'h7E, 4'b1100});
        check("t6_fast_stb", 12'(act_o[f6a + LAT][3]), 12'd1);
        check("t6_slow", act_o[f6b + LAT], {8'h96, 4'b1101});
        check("t7_rd_same_clk", act_o[f7 + LAT], {8'h5A, 4'b1100});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
